// File: rtl/column_readout_mux.sv
// Registered column readout mux: single-channel capture or auto-scan over a valid/ready stream.
// Optional build macro COLUMN_MUX_MASK_EN adds channel_mask to restrict the auto-scan.
module column_readout_mux #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SEL_W        = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               mode,
    input  logic [SEL_W-1:0]                   sel_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
`ifdef COLUMN_MUX_MASK_EN
    input  logic [NUM_CHANNELS-1:0]            channel_mask,
`endif
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [SEL_W-1:0]                   out_channel,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);

    typedef enum logic [1:0] {StIdle, StSingle, StScan} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]        out_channel_q, out_channel_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    done_q, done_d;
    logic [NUM_CHANNELS-1:0] mask_start, mask_q;
    logic                    xfer;

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [SEL_W:0] next_set(input logic [NUM_CHANNELS-1:0] mask,
                                                input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (i >= lo && mask[i]) r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

    // Out-of-range selectors read as zero.
    function automatic logic [DATA_WIDTH-1:0] pick(
        input logic [NUM_CHANNELS*DATA_WIDTH-1:0] bus, input logic [SEL_W-1:0] idx);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (idx == SEL_W'(i)) r = bus[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return r;
    endfunction

`ifdef COLUMN_MUX_MASK_EN
    assign mask_start = channel_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (state_q == StIdle && start && !mode) begin
            mask_q <= channel_mask;
        end
    end
`else
    assign mask_start = '1;
    assign mask_q     = '1;
`endif

    logic [SEL_W:0] first_ch, first_above, step_ch, step_above;

    assign first_ch    = next_set(mask_start, 0);
    assign first_above = next_set(mask_start, int'(first_ch[SEL_W-1:0]) + 1);
    assign step_ch     = next_set(mask_q, int'(out_channel_q) + 1);
    assign step_above  = next_set(mask_q, int'(step_ch[SEL_W-1:0]) + 1);
    assign xfer        = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (mode)             state_d = StSingle;
                    else if (first_ch[SEL_W]) state_d = StScan;
                end
            end
            StSingle: if (xfer) state_d = StIdle;
            StScan:   if (xfer && out_last_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        done_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && mode) begin
                    out_data_d    = pick(in_data, sel_in);
                    out_channel_d = sel_in;
                    out_valid_d   = 1'b1;
                    out_last_d    = 1'b1;
                end else if (start && first_ch[SEL_W]) begin
                    out_data_d    = pick(in_data, first_ch[SEL_W-1:0]);
                    out_channel_d = first_ch[SEL_W-1:0];
                    out_valid_d   = 1'b1;
                    out_last_d    = !first_above[SEL_W];
                end else if (start) begin
                    // Empty scan set: no beats, just the completion pulse.
                    done_d = 1'b1;
                end
            end
            StSingle, StScan: begin
                if (xfer && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end else if (xfer) begin
                    out_data_d    = pick(in_data, step_ch[SEL_W-1:0]);
                    out_channel_d = step_ch[SEL_W-1:0];
                    out_last_d    = !step_above[SEL_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_column_readout_mux.sv
// Self-checking bench for column_readout_mux: directed vector table, reset/mask sequences,
// and randomized traffic against a queue-based transaction model.
module tb_column_readout_mux;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, mode, out_ready;
    logic [SW-1:0]   sel_in;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    mask_v;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_channel;
    logic            out_valid, out_last, busy, done;

    column_readout_mux #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .sel_in      (sel_in),
        .in_data     (in_data),
`ifdef COLUMN_MUX_MASK_EN
        .channel_mask(mask_v),
`endif
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: a queue of channels still to be delivered.
    int            m_list[$];
    bit            m_active;
    logic [DW-1:0] e_data;
    int            e_chan;
    logic          e_valid, e_last, e_done;

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] bus, input int ch);
        return (ch < N) ? bus[ch*DW +: DW] : '0;
    endfunction

    task automatic m_reset();
        m_list.delete();
        m_active = 0;
        e_valid = 0; e_last = 0; e_done = 0; e_data = '0; e_chan = 0;
    endtask

    task automatic m_load();
        e_chan = m_list.pop_front();
        e_data = slice(in_data, e_chan);
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic m_edge();
        logic [N-1:0] m;
`ifdef COLUMN_MUX_MASK_EN
        m = mask_v;
`else
        m = '1;
`endif
        e_done = 0;
        if (!m_active) begin
            if (start) begin
                m_list.delete();
                if (mode) m_list.push_back(int'(sel_in));
                else for (int c = 0; c < N; c++) if (m[c]) m_list.push_back(c);
                if (m_list.size() == 0) e_done = 1;
                else begin m_active = 1; m_load(); end
            end
        end else if (out_ready) begin
            if (m_list.size() == 0) begin m_active = 0; e_done = 1; end
            else m_load();
        end
        e_valid = m_active;
        e_last  = m_active && (m_list.size() == 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_chk(input logic s, input logic md, input logic [SW-1:0] sl,
                             input logic rdy);
        start = s; mode = md; sel_in = sl; out_ready = rdy;
        m_edge();
        step();
        chk("valid", out_valid, e_valid);
        chk("busy",  busy,  e_valid);
        chk("done",  done,  e_done);
        chk("last",  out_last, e_last);
        if (e_valid) begin
            chk("data", out_data, e_data);
            chk("chan", out_channel, e_chan);
        end
    endtask

    task automatic do_reset();
        start = 0; mode = 0; sel_in = '0; out_ready = 0;
        reset = 1;
        step();
        reset = 0;
        m_reset();
    endtask

    typedef struct {
        logic          start, mode, ready;
        logic [SW-1:0] sel;
        logic          valid, last, busy, done;
        logic [DW-1:0] data;
        logic [SW-1:0] chan;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic md, input int sl, input logic r,
                                input logic v, input int d, input int ch, input logic l,
                                input logic b, input logic dn);
        vec_t x;
        x.start = s; x.mode = md; x.sel = SW'(sl); x.ready = r;
        x.valid = v; x.data = DW'(d); x.chan = SW'(ch); x.last = l; x.busy = b; x.done = dn;
        return x;
    endfunction

    vec_t vecs[19];

    initial begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(8'h10 + i);
        mask_v = '1;
        start = 0; mode = 0; sel_in = '0; out_ready = 0; reset = 1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_chan",  out_channel, 0);
        chk("rst_last",  out_last, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        step();
        reset = 0;

        //            st md sel rdy  v  data ch l  b  dn
        vecs[0]  = mk(1, 1, 5, 1,   1, 'h15, 5, 1, 1, 0);
        vecs[1]  = mk(0, 0, 0, 1,   0, 0,    0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1,   0, 0,    0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1,   1, 'h10, 0, 0, 1, 0);
        vecs[4]  = mk(1, 1, 6, 1,   1, 'h11, 1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 1,   1, 'h12, 2, 0, 1, 0);
        vecs[6]  = mk(1, 1, 4, 0,   1, 'h12, 2, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0,   1, 'h12, 2, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0,   1, 'h12, 2, 0, 1, 0);
        vecs[9]  = mk(0, 0, 0, 1,   1, 'h13, 3, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 1,   1, 'h14, 4, 0, 1, 0);
        vecs[11] = mk(1, 0, 0, 1,   1, 'h15, 5, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 1,   1, 'h16, 6, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 1,   1, 'h17, 7, 1, 1, 0);
        vecs[14] = mk(1, 1, 1, 1,   0, 0,    0, 0, 0, 1);
        vecs[15] = mk(1, 1, 3, 0,   1, 'h13, 3, 1, 1, 0);
        vecs[16] = mk(0, 0, 0, 0,   1, 'h13, 3, 1, 1, 0);
        vecs[17] = mk(0, 0, 0, 1,   0, 0,    0, 0, 0, 1);
        vecs[18] = mk(1, 0, 0, 1,   1, 'h10, 0, 0, 1, 0);

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; mode = vecs[i].mode;
            sel_in = vecs[i].sel; out_ready = vecs[i].ready;
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].valid);
            chk($sformatf("v%0d_last", i),  out_last,  vecs[i].last);
            chk($sformatf("v%0d_busy", i),  busy,      vecs[i].busy);
            chk($sformatf("v%0d_done", i),  done,      vecs[i].done);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_data", i), out_data,    vecs[i].data);
                chk($sformatf("v%0d_chan", i), out_channel, vecs[i].chan);
            end
        end

        // Reset mid-scan after three more beats transfer.
        start = 0; out_ready = 1;
        step(); step(); step();
        chk("pre_rst_chan", out_channel, 3);
        #2 reset = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data",  out_data, 0);
        chk("arst_chan",  out_channel, 0);
        chk("arst_last",  out_last, 0);
        chk("arst_busy",  busy, 0);
        chk("arst_done",  done, 0);
        step();
        reset = 0;
        step();
        chk("post_rst_done", done, 0);
        m_reset();
        cycle_chk(1, 0, 0, 1);
        chk("rescan_chan", out_channel, 0);

`ifdef COLUMN_MUX_MASK_EN
        do_reset();
        mask_v = 8'b1010_0100;
        cycle_chk(1, 0, 0, 1);
        chk("mask_ch_a", out_channel, 2);
        mask_v = '0;
        cycle_chk(0, 0, 0, 1);
        chk("mask_ch_b", out_channel, 5);
        cycle_chk(0, 0, 0, 1);
        chk("mask_ch_c", out_channel, 7);
        chk("mask_last", out_last, 1);
        cycle_chk(0, 0, 0, 1);
        chk("mask_done", done, 1);
        cycle_chk(1, 0, 0, 1);
        chk("mask0_valid", out_valid, 0);
        chk("mask0_done", done, 1);
        mask_v = '1;
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
`ifdef COLUMN_MUX_MASK_EN
            mask_v = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
`endif
            cycle_chk(($urandom_range(0, 3) == 0), 1'($urandom), SW'($urandom),
                      ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
